// File: rtl/fp_align_stage.sv
// Pre-adder alignment stage for binary32 add/sub: unpack, compare/swap (stage 1),
// align the smaller significand with guard/round/sticky (stage 2), valid/ready on both sides.
module fp_align_stage #(
  parameter int EXP_W     = 8,
  parameter int FRAC_W    = 23,
  parameter int SHIFT_SAT = 26
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   in_a,
  input  logic [EXP_W+FRAC_W:0]   in_b,
  input  logic                    in_sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FRAC_W-1:0]       out_mant_a,
  output logic [FRAC_W-1:0]       out_mant_b,
  output logic                    out_hid_a,
  output logic                    out_hid_b,
  output logic [2:0]              out_grs,
  output logic                    out_cin,
  output logic [EXP_W-1:0]        out_exp,
  output logic                    out_sign,
  output logic                    out_special,
  output logic [EXP_W+FRAC_W:0]   out_special_val
);

  localparam int W     = 1 + EXP_W + FRAC_W;
  localparam int SIG_W = FRAC_W + 1;
  localparam int XW    = 2 * SIG_W + 2;
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] SAT_D   = EXP_W'(SHIFT_SAT);

  // ---------------- unpack / compare ----------------
  logic              w_sa, w_sb_eff, w_eff_sub, w_swap, w_mag_eq, w_sign;
  logic              w_hid_a, w_hid_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b, w_special;
  logic [EXP_W-1:0]  w_ea, w_eb, w_effexp_a, w_effexp_b;
  logic [FRAC_W-1:0] w_fa, w_fb;
  logic [W-1:0]      w_special_val;

  assign w_sa       = in_a[W-1];
  assign w_ea       = in_a[W-2 -: EXP_W];
  assign w_fa       = in_a[FRAC_W-1:0];
  assign w_eb       = in_b[W-2 -: EXP_W];
  assign w_fb       = in_b[FRAC_W-1:0];
  assign w_sb_eff   = in_b[W-1] ^ in_sub;
  assign w_eff_sub  = w_sa ^ w_sb_eff;
  assign w_hid_a    = (w_ea != '0);
  assign w_hid_b    = (w_eb != '0);
  assign w_effexp_a = w_hid_a ? w_ea : EXP_W'(1);
  assign w_effexp_b = w_hid_b ? w_eb : EXP_W'(1);
  assign w_swap     = in_b[W-2:0] > in_a[W-2:0];
  assign w_mag_eq   = in_b[W-2:0] == in_a[W-2:0];
  // Exact cancellation under effective subtract yields +0 in round-to-nearest.
  assign w_sign     = w_swap ? w_sb_eff : ((w_mag_eq && w_eff_sub) ? 1'b0 : w_sa);

  assign w_inf_a    = (w_ea == EXP_MAX) && (w_fa == '0);
  assign w_inf_b    = (w_eb == EXP_MAX) && (w_fb == '0);
  assign w_nan_a    = (w_ea == EXP_MAX) && (w_fa != '0);
  assign w_nan_b    = (w_eb == EXP_MAX) && (w_fb != '0);
  assign w_special  = (w_ea == EXP_MAX) || (w_eb == EXP_MAX);

  always_comb begin
    w_special_val = '0;
    if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && w_eff_sub))
      w_special_val = {1'b0, EXP_MAX, 1'b1, {(FRAC_W-1){1'b0}}};
    else if (w_inf_a)
      w_special_val = {w_sa, EXP_MAX, {FRAC_W{1'b0}}};
    else if (w_inf_b)
      w_special_val = {w_sb_eff, EXP_MAX, {FRAC_W{1'b0}}};
  end

  // ---------------- handshake ----------------
  logic r_en, r1_valid, r2_valid;
  logic w_s1_adv, w_s2_adv, w_in_fire;

  assign w_s2_adv  = !r2_valid || out_ready;
  assign w_s1_adv  = !r1_valid || w_s2_adv;
  assign in_ready  = w_s1_adv && r_en;
  assign w_in_fire = in_valid && in_ready;

  // ---------------- stage 1 registers ----------------
  logic [SIG_W-1:0] r1_sig_l, r1_sig_s;
  logic [EXP_W-1:0] r1_exp, r1_d;
  logic             r1_sign, r1_sub, r1_special;
  logic [W-1:0]     r1_special_val;

  // NOTE: datapath registers are reset as well, so every output reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en           <= 1'b0;
      r1_valid       <= 1'b0;
      r1_sig_l       <= '0;
      r1_sig_s       <= '0;
      r1_exp         <= '0;
      r1_d           <= '0;
      r1_sign        <= 1'b0;
      r1_sub         <= 1'b0;
      r1_special     <= 1'b0;
      r1_special_val <= '0;
    end else begin
      r_en <= 1'b1;
      if (w_s1_adv) begin
        r1_valid <= w_in_fire;
        if (w_in_fire) begin
          r1_sig_l       <= w_swap ? {w_hid_b, w_fb} : {w_hid_a, w_fa};
          r1_sig_s       <= w_swap ? {w_hid_a, w_fa} : {w_hid_b, w_fb};
          r1_exp         <= w_swap ? w_effexp_b : w_effexp_a;
          r1_d           <= w_swap ? (w_effexp_b - w_effexp_a) : (w_effexp_a - w_effexp_b);
          r1_sign        <= w_sign;
          r1_sub         <= w_eff_sub;
          r1_special     <= w_special;
          r1_special_val <= w_special_val;
        end
      end
    end
  end

  // ---------------- stage 2 alignment ----------------
  logic [XW-1:0]     w_shifted;
  logic              w_sat, w_hid_s;
  logic [FRAC_W-1:0] w_mant_s;
  logic [2:0]        w_grs;

  // Two spare LSB slots plus a full significand's worth of room keep every shifted-out bit below d<SHIFT_SAT.
  assign w_shifted = {r1_sig_s, {(SIG_W+2){1'b0}}} >> r1_d;
  assign w_sat     = (r1_d >= SAT_D);

  always_comb begin
    w_hid_s  = w_shifted[XW-1];
    w_mant_s = w_shifted[XW-2 -: FRAC_W];
    w_grs    = {w_shifted[SIG_W+1], w_shifted[SIG_W], |w_shifted[SIG_W-1:0]};
    if (w_sat) begin
      w_hid_s  = 1'b0;
      w_mant_s = '0;
      w_grs    = {2'b00, |r1_sig_s};
    end
  end

  logic [FRAC_W-1:0] r2_mant_a, r2_mant_b;
  logic              r2_hid_a, r2_hid_b, r2_cin, r2_sign, r2_special;
  logic [2:0]        r2_grs;
  logic [EXP_W-1:0]  r2_exp;
  logic [W-1:0]      r2_special_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid       <= 1'b0;
      r2_mant_a      <= '0;
      r2_mant_b      <= '0;
      r2_hid_a       <= 1'b0;
      r2_hid_b       <= 1'b0;
      r2_grs         <= '0;
      r2_cin         <= 1'b0;
      r2_exp         <= '0;
      r2_sign        <= 1'b0;
      r2_special     <= 1'b0;
      r2_special_val <= '0;
    end else if (w_s2_adv) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_mant_a      <= r1_sig_l[FRAC_W-1:0];
        r2_hid_a       <= r1_sig_l[SIG_W-1];
        r2_mant_b      <= w_mant_s;
        r2_hid_b       <= w_hid_s;
        r2_grs         <= w_grs;
        r2_cin         <= r1_sub;
        r2_exp         <= r1_exp;
        r2_sign        <= r1_sign;
        r2_special     <= r1_special;
        r2_special_val <= r1_special_val;
      end
    end
  end

  assign out_valid       = r2_valid;
  assign out_mant_a      = r2_mant_a;
  assign out_mant_b      = r2_mant_b;
  assign out_hid_a       = r2_hid_a;
  assign out_hid_b       = r2_hid_b;
  assign out_grs         = r2_grs;
  assign out_cin         = r2_cin;
  assign out_exp         = r2_exp;
  assign out_sign        = r2_sign;
  assign out_special     = r2_special;
  assign out_special_val = r2_special_val;

endmodule

// File: tb/tb_fp_align_stage.sv
// Self-checking bench for fp_align_stage: directed vectors, backpressure, reset flush,
// and randomized traffic against an arithmetic reference model.
module tb_fp_align_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_special_val;
  logic [22:0] out_mant_a, out_mant_b;
  logic        out_hid_a, out_hid_b, out_cin, out_sign, out_special;
  logic [2:0]  out_grs;
  logic [7:0]  out_exp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_align_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant_a(out_mant_a), .out_mant_b(out_mant_b),
    .out_hid_a(out_hid_a), .out_hid_b(out_hid_b),
    .out_grs(out_grs), .out_cin(out_cin), .out_exp(out_exp),
    .out_sign(out_sign), .out_special(out_special),
    .out_special_val(out_special_val)
  );

  typedef struct packed {
    logic [22:0] mant_a;
    logic [22:0] mant_b;
    logic        hid_a;
    logic        hid_b;
    logic [2:0]  grs;
    logic        cin;
    logic [7:0]  exp;
    logic        sign;
    logic        special;
    logic [31:0] sval;
  } res_t;

  // Reference model: plain integer arithmetic on the unpacked operands.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    res_t r;
    int unsigned ea, eb, effa, effb, siga, sigb, ma, mb, sigl, sigs, el, d, kept;
    logic sa, sbe, es, swap, nan_a, nan_b, inf_a, inf_b, g, rr, st;
    r    = '0;
    ea   = a[30:23];
    eb   = b[30:23];
    ma   = a[30:0];
    mb   = b[30:0];
    sa   = a[31];
    sbe  = b[31] ^ sub;
    es   = sa ^ sbe;
    effa = (ea == 0) ? 1 : ea;
    effb = (eb == 0) ? 1 : eb;
    siga = ((ea != 0) ? 32'h800000 : 32'h0) + a[22:0];
    sigb = ((eb != 0) ? 32'h800000 : 32'h0) + b[22:0];
    swap = (mb > ma);
    if (swap) begin
      sigl = sigb; sigs = siga; el = effb; d = effb - effa; r.sign = sbe;
    end else begin
      sigl = siga; sigs = sigb; el = effa; d = effa - effb;
      r.sign = (ma == mb && es) ? 1'b0 : sa;
    end
    r.cin    = es;
    r.exp    = el[7:0];
    r.hid_a  = sigl[23];
    r.mant_a = sigl[22:0];
    if (d >= 26) begin
      r.hid_b = 1'b0; r.mant_b = '0; r.grs = {2'b00, sigs != 0};
    end else begin
      kept     = sigs >> d;
      r.hid_b  = kept[23];
      r.mant_b = kept[22:0];
      g  = (d >= 1) ? ((sigs >> (d - 1)) & 1) != 0 : 1'b0;
      rr = (d >= 2) ? ((sigs >> (d - 2)) & 1) != 0 : 1'b0;
      st = (d >= 3) ? (sigs & ((32'd1 << (d - 2)) - 1)) != 0 : 1'b0;
      r.grs = {g, rr, st};
    end
    nan_a = (ea == 255) && (a[22:0] != 0);
    nan_b = (eb == 255) && (b[22:0] != 0);
    inf_a = (ea == 255) && (a[22:0] == 0);
    inf_b = (eb == 255) && (b[22:0] == 0);
    r.special = (ea == 255) || (eb == 255);
    if (nan_a || nan_b || (inf_a && inf_b && es)) r.sval = 32'h7FC00000;
    else if (inf_a)                               r.sval = {sa, 8'hFF, 23'h0};
    else if (inf_b)                               r.sval = {sbe, 8'hFF, 23'h0};
    if (r.special) begin
      r.mant_a = '0; r.mant_b = '0; r.hid_a = 1'b0; r.hid_b = 1'b0; r.grs = '0;
    end
    return r;
  endfunction

  function automatic res_t observe(input logic mask);
    res_t r;
    r.mant_a = out_mant_a; r.mant_b = out_mant_b; r.hid_a = out_hid_a; r.hid_b = out_hid_b;
    r.grs = out_grs; r.cin = out_cin; r.exp = out_exp; r.sign = out_sign;
    r.special = out_special; r.sval = out_special_val;
    if (mask) begin
      r.mant_a = '0; r.mant_b = '0; r.hid_a = 1'b0; r.hid_b = 1'b0; r.grs = '0;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_fp(input logic [31:0] ref_v);
    logic [31:0] v;
    int e;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:23] = 8'h00;
      1: begin v[30:23] = 8'hFF; if ($urandom_range(0, 1) == 1) v[22:0] = '0; end
      2, 3, 4: begin
        e = int'(ref_v[30:23]) - int'($urandom_range(0, 30));
        if (e < 0) e = 0;
        v[30:23] = 8'(e);
      end
      5: v[30:0] = ref_v[30:0];
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  // Offers one operand pair into an idle pipeline; lat = cycles until out_valid, -1 on timeout.
  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          output res_t got, output int lat);
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    got = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid) begin lat = k; got = observe(1'b0); break; end
    end
  endtask

  task automatic test_reset;
    #12;
    total++;
    if (observe(1'b0) !== res_t'(0) || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_outputs got=%h valid=%b ready=%b want all 0", observe(1'b0), out_valid, in_ready);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want 1", in_ready); end
  endtask

  task automatic test_vector(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic sub, input res_t e);
    res_t got;
    int   lat;
    send_one(a, b, sub, got, lat);
    total++;
    if (lat != 2) begin bad++; $display("FAIL %s_latency got=%0d want 2", name, lat); end
    total++;
    if (got !== e) begin bad++; $display("FAIL %s got=%h want %h", name, got, e); end
  endtask

  task automatic test_directed;
    res_t e;
    e = '0; e.hid_a = 1; e.hid_b = 1; e.exp = 8'h7F;
    test_vector("add_1p1", 32'h3F800000, 32'h3F800000, 1'b0, e);
    e = '0; e.hid_a = 1; e.mant_b = 23'h400000; e.cin = 1; e.exp = 8'h7F;
    test_vector("sub_1m05", 32'h3F800000, 32'h3F000000, 1'b1, e);
    e = '0; e.hid_a = 1; e.mant_b = 23'h200000; e.cin = 1; e.exp = 8'h80; e.sign = 1;
    test_vector("swap", 32'h3F000000, 32'hC0000000, 1'b0, e);
    e = '0; e.hid_a = 1; e.exp = 8'h7F; e.grs = 3'b001;
    test_vector("far_shift30", 32'h3F800000, 32'h30800000, 1'b0, e);
    e = '0; e.hid_a = 1; e.exp = 8'h7F; e.grs = 3'b110;
    test_vector("shift24_gr", 32'h3F800000, 32'h33C00000, 1'b0, e);
  endtask

  task automatic test_specials;
    logic [31:0] va[4], vb[4], want[4];
    logic        vs[4];
    res_t        got;
    int          lat;
    va = '{32'h7F800000, 32'h7F800000, 32'h3F800000, 32'h7FC12345};
    vb = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 32'h3F800000};
    vs = '{1'b1, 1'b0, 1'b1, 1'b0};
    want = '{32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'h7FC00000};
    for (int i = 0; i < 4; i++) begin
      send_one(va[i], vb[i], vs[i], got, lat);
      total++;
      if (lat != 2 || got.special !== 1'b1 || got.sval !== want[i]) begin
        bad++;
        $display("FAIL special_%0d got lat=%0d special=%b val=%h want lat=2 special=1 val=%h",
                 i, lat, got.special, got.sval, want[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    res_t        q[$];
    logic [31:0] va[4], vb[4];
    logic        vs[4];
    int          idx, drains, gaps;
    for (int i = 0; i < 4; i++) begin
      va[i] = rand_fp($urandom); vb[i] = rand_fp(va[i]); vs[i] = 1'($urandom);
    end
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; idx = 0;
    in_a = va[0]; in_b = vb[0]; in_sub = vs[0];
    repeat (6) begin
      @(negedge clk);
      if (out_valid) begin
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL bp_stall_extra got valid want none"); end
        else if (observe(q[0].special) !== q[0]) begin
          bad++; $display("FAIL bp_stall_hold got=%h want %h", observe(q[0].special), q[0]);
        end
      end
      if (in_valid && in_ready) begin q.push_back(model(in_a, in_b, in_sub)); idx++; end
      @(posedge clk); #1;
      if (idx < 4) begin in_a = va[idx]; in_b = vb[idx]; in_sub = vs[idx]; end
      else in_valid = 1'b0;
    end
    total++;
    if (idx != 2) begin bad++; $display("FAIL bp_accepted got=%0d want 2", idx); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want 0", in_ready); end
    out_ready = 1'b1; drains = 0; gaps = 0;
    for (int c = 0; c < 12 && drains < 4; c++) begin
      @(negedge clk);
      if (out_valid) begin
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL bp_drain_extra got valid want none"); end
        else begin
          if (observe(q[0].special) !== q[0]) begin
            bad++; $display("FAIL bp_drain_%0d got=%h want %h", drains, observe(q[0].special), q[0]);
          end
          void'(q.pop_front());
        end
        drains++;
      end else gaps++;
      if (in_valid && in_ready) begin q.push_back(model(in_a, in_b, in_sub)); idx++; end
      @(posedge clk); #1;
      if (idx < 4) begin in_a = va[idx]; in_b = vb[idx]; in_sub = vs[idx]; end
      else in_valid = 1'b0;
    end
    total++;
    if (drains != 4 || gaps != 0) begin
      bad++; $display("FAIL bp_stream got drains=%0d gaps=%0d want 4 and 0", drains, gaps);
    end
  endtask

  task automatic test_reset_flush;
    int stale;
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b0; in_a = 32'h3F800000; in_b = 32'h40000000; in_sub = 1'b0;
    @(posedge clk); #1;
    in_a = 32'h40400000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL flush_full got valid=%b ready=%b want 1 0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || observe(1'b0) !== res_t'(0)) begin
      bad++; $display("FAIL flush_async got valid=%b out=%h want 0", out_valid, observe(1'b0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b want 1", in_ready); end
    stale = 0;
    repeat (6) begin @(negedge clk); if (out_valid) stale++; end
    total++;
    if (stale != 0) begin bad++; $display("FAIL flush_stale got=%0d want 0", stale); end
  endtask

  task automatic test_random;
    res_t        q[$];
    logic [31:0] a, b, t;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      a = rand_fp($urandom);
      b = rand_fp(a);
      if ($urandom_range(0, 1) == 1) begin t = a; a = b; b = t; end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a = a; in_b = b; in_sub = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_valid) begin
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL rand_extra got valid want none"); end
        else begin
          if (observe(q[0].special) !== q[0]) begin
            bad++; $display("FAIL rand_%0d got=%h want %h", c, observe(q[0].special), q[0]);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_sub));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) begin
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL rand_drain_extra got valid want none"); end
        else begin
          if (observe(q[0].special) !== q[0]) begin
            bad++; $display("FAIL rand_drain got=%h want %h", observe(q[0].special), q[0]);
          end
          void'(q.pop_front());
        end
      end
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL rand_lost got=%0d pending want 0", q.size()); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
    test_reset();
    test_directed();
    test_specials();
    test_backpressure();
    test_reset_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
